file_stream_arb: RTL and testbench

FILE_STREAM_ARB -- requirements
Module: file_stream_arb

---
 rtl/file_stream_arb_pkg.sv | 16 +
 rtl/file_stream_arb_rr.sv | 38 +++
 rtl/file_stream_arb.sv | 161 ++++++++++++++++
 tb/tb_file_stream_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/file_stream_arb_pkg.sv
// Shared file-access definitions: FSM encoding and default chunk/timeout sizes
// for the two-client streaming file arbiter.
package file_stream_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } fsa_state_e;

  localparam int unsigned CHUNK_LEN_DEF = 1024;
  localparam int unsigned TIMEOUT_DEF   = 16777215;
  localparam int unsigned BCNT_W        = 11;

endpackage

// File: rtl/file_stream_arb_rr.sv
// Two-way round-robin arbiter: the client not granted last wins a tie.
// The pointer doubles as "currently granted client" once a grant is taken.
module file_rr_arb2 (
  input  logic       clk,
  input  logic       resetq,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       last_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (grant_o != 2'b00)) begin
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/file_stream_arb.sv
// Arbitrates two clients onto one streaming file reader: issues the request,
// routes each returned byte to the granted client, and aborts on idle timeout.
//
// state     | meaning
// ST_IDLE   | waiting for a client request; arbiter picks one
// ST_ISSUE  | f_req_valid held with latched offset until f_req_ready
// ST_STREAM | forwarding bytes to the granted client, byte and idle counters live
// ST_DONE   | one-cycle chunk-complete pulse, then back to idle
module file_stream_arb
  import file_stream_arb_pkg::*;
#(
  parameter int unsigned CHUNK_LEN = CHUNK_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        c0_req_valid,
  input  logic [31:0] c0_req_offset,
  output logic        c0_req_ready,
  output logic [7:0]  c0_data,
  output logic        c0_data_valid,
  output logic        c0_done,
  output logic        c0_error,
  input  logic        c1_req_valid,
  input  logic [31:0] c1_req_offset,
  output logic        c1_req_ready,
  output logic [7:0]  c1_data,
  output logic        c1_data_valid,
  output logic        c1_done,
  output logic        c1_error,
  output logic        f_req_valid,
  output logic [31:0] f_req_offset,
  input  logic        f_req_ready,
  input  logic [7:0]  f_data,
  input  logic        f_data_avail,
  output logic        busy,
  output logic        stray
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(CHUNK_LEN - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT);

  fsa_state_e        state_q, state_d;
  logic [31:0]       off_q, off_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        dv_q, dv_d;
  logic [1:0]        err_q, err_d;
  logic              stray_q, stray_d;

  logic [1:0] rr_grant;
  logic       rr_last;
  logic [1:0] gsel_onehot;

  file_rr_arb2 u_rr (
    .clk       (clk),
    .resetq    (resetq),
    .valid_i   ({c1_req_valid, c0_req_valid}),
    .advance_i (state_q == ST_IDLE),
    .grant_o   (rr_grant),
    .last_o    (rr_last)
  );

  // After a grant the arbiter pointer holds the client being served.
  assign gsel_onehot = rr_last ? 2'b10 : 2'b01;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    dv_d    = 2'b00;
    err_d   = 2'b00;
    stray_d = stray_q;

    if (f_data_avail && (state_q != ST_STREAM)) begin
      stray_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rr_grant != 2'b00) begin
          off_d   = rr_grant[1] ? c1_req_offset : c0_req_offset;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (f_req_ready) begin
          cnt_d   = '0;
          tmr_d   = TMR_LOAD;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (f_data_avail) begin
          data_d = f_data;
          dv_d   = gsel_onehot;
          tmr_d  = TMR_LOAD;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_q == TMR_W'(1)) begin
          err_d   = gsel_onehot;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      dv_q    <= '0;
      err_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  // Ready is combinational from the IDLE grant, so it is forced low during reset.
  assign c0_req_ready  = resetq && (state_q == ST_IDLE) && rr_grant[0];
  assign c1_req_ready  = resetq && (state_q == ST_IDLE) && rr_grant[1];
  assign f_req_valid   = (state_q == ST_ISSUE);
  assign f_req_offset  = off_q;
  assign c0_data       = data_q;
  assign c1_data       = data_q;
  assign c0_data_valid = dv_q[0];
  assign c1_data_valid = dv_q[1];
  assign c0_done       = (state_q == ST_DONE) && !rr_last;
  assign c1_done       = (state_q == ST_DONE) && rr_last;
  assign c0_error      = err_q[0];
  assign c1_error      = err_q[1];
  assign busy          = (state_q != ST_IDLE);
  assign stray         = stray_q;

endmodule

// File: tb/tb_file_stream_arb.sv
// Directed bench for file_stream_arb: a reader model drives bytes into a
// scoreboard queue and a negedge monitor pops and checks the routed output.
module tb_file_stream_arb;

  localparam int CHUNK = 1024;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        c0_req_valid = 1'b0, c1_req_valid = 1'b0;
  logic [31:0] c0_req_offset = '0, c1_req_offset = '0;
  logic        c0_req_ready, c1_req_ready;
  logic [7:0]  c0_data, c1_data;
  logic        c0_data_valid, c1_data_valid;
  logic        c0_done, c1_done, c0_error, c1_error;
  logic        f_req_valid;
  logic [31:0] f_req_offset;
  logic        f_req_ready = 1'b0;
  logic [7:0]  f_data = '0;
  logic        f_data_avail = 1'b0;
  logic        busy, stray;

  file_stream_arb #(.CHUNK_LEN(CHUNK), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetq(resetq),
    .c0_req_valid(c0_req_valid), .c0_req_offset(c0_req_offset), .c0_req_ready(c0_req_ready),
    .c0_data(c0_data), .c0_data_valid(c0_data_valid), .c0_done(c0_done), .c0_error(c0_error),
    .c1_req_valid(c1_req_valid), .c1_req_offset(c1_req_offset), .c1_req_ready(c1_req_ready),
    .c1_data(c1_data), .c1_data_valid(c1_data_valid), .c1_done(c1_done), .c1_error(c1_error),
    .f_req_valid(f_req_valid), .f_req_offset(f_req_offset), .f_req_ready(f_req_ready),
    .f_data(f_data), .f_data_avail(f_data_avail), .busy(busy), .stray(stray)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cl;
    logic [7:0] b;
  } sb_t;

  sb_t sb[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  rdy_cnt[2], done_cnt[2], err_cnt[2], dv_cnt[2];
  int  nbytes = 0, freq_cnt = 0, last_dv_cyc = 0, err_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      rdy_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0; dv_cnt[i] = 0;
    end
    freq_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!resetq) begin
      nbytes = 0;
    end else begin
      if (c0_req_ready) rdy_cnt[0]++;
      if (c1_req_ready) rdy_cnt[1]++;
      if (f_req_valid && f_req_ready) freq_cnt++;
      if (c0_data_valid || c1_data_valid) begin
        if (sb.size() == 0) begin
          chk("dv_unexpected", {30'd0, c1_data_valid, c0_data_valid}, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("dv_client", {30'd0, c1_data_valid, c0_data_valid}, e.cl ? 32'd2 : 32'd1);
          chk("data_byte", 32'(c1_data_valid ? c1_data : c0_data), 32'(e.b));
          nbytes++;
          last_dv_cyc = cyc;
          if (c0_data_valid) dv_cnt[0]++; else dv_cnt[1]++;
        end
      end
      if (c0_done || c1_done) begin
        chk("done_with_dv", 32'(c0_done ? c0_data_valid : c1_data_valid), 32'd1);
        chk("chunk_len", nbytes, CHUNK);
        nbytes = 0;
        if (c0_done) done_cnt[0]++; else done_cnt[1]++;
      end
      if (c0_error) begin err_cnt[0]++; err_cyc = cyc; end
      if (c1_error) begin err_cnt[1]++; err_cyc = cyc; end
    end
  end

  task automatic expect_grant(input int cl);
    int w = 0;
    @(negedge clk);
    while (!(c0_req_ready || c1_req_ready) && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("grant", {30'd0, c1_req_ready, c0_req_ready}, (cl == 1) ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    if (cl == 0) c0_req_valid = 1'b0; else c1_req_valid = 1'b0;
  endtask

  task automatic send(input logic cl, input int n, input bit rnd);
    sb_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      f_data       = rnd ? 8'($urandom) : 8'(i);
      f_data_avail = 1'b1;
      e.cl = cl;
      e.b  = f_data;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    f_data_avail = 1'b0;
  endtask

  task automatic serve(input logic [31:0] off, input logic cl, input int n,
                       input int rdly, input bit rnd);
    int w = 0;
    while (f_req_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("f_req_seen", 32'(f_req_valid), 32'd1);
    chk("f_req_offset", f_req_offset, off);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(f_req_valid), 32'd1);
      chk("hold_offset", f_req_offset, off);
    end
    @(posedge clk); #1;
    f_req_ready = 1'b1;
    @(posedge clk); #1;
    f_req_ready = 1'b0;
    @(negedge clk);
    chk("stream_entry_req_low", 32'(f_req_valid), 32'd0);
    chk("stream_entry_busy", 32'(busy), 32'd1);
    send(cl, n, rnd);
  endtask

  initial begin
    int w;
    clear_counts();

    // reset values, with a request pending during reset
    c0_req_valid = 1'b1;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_f_req_valid", 32'(f_req_valid), 32'd0);
    chk("rst_offset", f_req_offset, 32'd0);
    chk("rst_stray", 32'(stray), 32'd0);
    chk("rst_ready0", 32'(c0_req_ready), 32'd0);
    chk("rst_dv", {30'd0, c1_data_valid, c0_data_valid}, 32'd0);
    c0_req_valid = 1'b0;
    resetq = 1'b1;
    tick(1);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // single client 0, full chunk, incrementing pattern
    @(posedge clk); #1;
    c0_req_offset = 32'h0000_1000;
    c0_req_valid  = 1'b1;
    expect_grant(0);
    serve(32'h0000_1000, 1'b0, CHUNK, 0, 1'b0);
    tick(3);
    chk("t1_done0", done_cnt[0], 1);
    chk("t1_done1", done_cnt[1], 0);
    chk("t1_dv0", dv_cnt[0], CHUNK);
    chk("t1_dv1", dv_cnt[1], 0);
    chk("t1_freq", freq_cnt, 1);
    chk("t1_busy", 32'(busy), 32'd0);

    // round robin from reset: tie -> c0, then second tie -> c1, then c0
    resetq = 1'b0;
    tick(2);
    clear_counts();
    resetq = 1'b1;
    tick(1);
    @(posedge clk); #1;
    c0_req_offset = 32'h0000_2000;
    c1_req_offset = 32'h0000_3000;
    c0_req_valid  = 1'b1;
    c1_req_valid  = 1'b1;
    expect_grant(0);
    serve(32'h0000_2000, 1'b0, CHUNK, 0, 1'b1);
    c0_req_offset = 32'h0000_4000;
    c0_req_valid  = 1'b1;
    expect_grant(1);
    serve(32'h0000_3000, 1'b1, CHUNK, 0, 1'b1);
    expect_grant(0);
    serve(32'h0000_4000, 1'b0, CHUNK, 0, 1'b1);
    tick(3);
    chk("t2_rdy0", rdy_cnt[0], 2);
    chk("t2_rdy1", rdy_cnt[1], 1);
    chk("t2_done0", done_cnt[0], 2);
    chk("t2_done1", done_cnt[1], 1);
    chk("t2_freq", freq_cnt, 3);

    // ready held off 50 cycles, then reader stalls after 10 bytes
    @(posedge clk); #1;
    c0_req_offset = 32'hABCD_0000;
    c0_req_valid  = 1'b1;
    expect_grant(0);
    serve(32'hABCD_0000, 1'b0, 10, 50, 1'b1);
    w = 0;
    while (err_cnt[0] == 0 && w < 300) begin
      tick(1);
      w++;
    end
    chk("tmo_seen", err_cnt[0], 1);
    chk("tmo_latency", err_cyc - last_dv_cyc, TMO);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_no_c1_err", err_cnt[1], 0);
    tick(1);
    chk("tmo_err_pulse", 32'(c0_error), 32'd0);
    chk("tmo_no_done", done_cnt[0], 2);
    chk("pre_late_stray", 32'(stray), 32'd0);
    @(posedge clk); #1;
    f_data = 8'h5A;
    f_data_avail = 1'b1;
    @(posedge clk); #1;
    f_data_avail = 1'b0;
    tick(1);
    chk("late_stray", 32'(stray), 32'd1);

    // reset in the middle of a stream
    @(posedge clk); #1;
    c0_req_offset = 32'h0000_0500;
    c0_req_valid  = 1'b1;
    expect_grant(0);
    serve(32'h0000_0500, 1'b0, 500, 0, 1'b1);
    @(negedge clk); #1;
    chk("mid_sb_empty", sb.size(), 0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    resetq = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_freq", 32'(f_req_valid), 32'd0);
    chk("mid_rst_offset", f_req_offset, 32'd0);
    chk("mid_rst_dv", {30'd0, c1_data_valid, c0_data_valid}, 32'd0);
    chk("mid_rst_data", 32'(c0_data), 32'd0);
    chk("mid_rst_done_err", {28'd0, c1_done, c0_done, c1_error, c0_error}, 32'd0);
    chk("mid_rst_stray", 32'(stray), 32'd0);
    tick(2);
    resetq = 1'b1;
    tick(1);

    // client 1 after release completes normally
    @(posedge clk); #1;
    c1_req_offset = 32'h00C0_FFEE;
    c1_req_valid  = 1'b1;
    expect_grant(1);
    serve(32'h00C0_FFEE, 1'b1, CHUNK, 0, 1'b1);
    tick(3);
    chk("t5_done1", done_cnt[1], 2);
    chk("t5_done0", done_cnt[0], 2);
    chk("t5_stray", 32'(stray), 32'd0);

    // byte in IDLE: dropped, sticky stray
    @(posedge clk); #1;
    f_data = 8'hA5;
    f_data_avail = 1'b1;
    @(posedge clk); #1;
    f_data_avail = 1'b0;
    tick(1);
    chk("idle_stray", 32'(stray), 32'd1);
    tick(5);
    chk("idle_stray_sticky", 32'(stray), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("end_c1_err", err_cnt[1], 0);
    chk("end_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
